lsu_master: RTL and testbench
=============================

Name: lsu_master

Overview:
- Load/store initiator between the execute stage and a word-organised data memory.
- Takes one load or store per request and issues word-wide memory transactions with byte enables over a valid/ready request channel and an in-order response channel.
- Produces sign- or zero-extended load data, or a store completion, back to the pipeline.
- Misaligned halfword/word accesses are split into two word transactions.

Parameters:
- MEM_AW, 30, word-address width (byte address bits [31:2])
- HC_ADDR, 32'hFFFF_FF00, byte address answered locally by hc_data for Lw (no memory transaction)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- req_valid  input  1  pipeline request present
- req_ready  output  1  request accepted when req_valid&&req_ready
- info_load  input  3  0 none, 1 Lb, 2 Lh, 3 Lw, 4 Lbu, 5 Lhu
- info_store  input  2  0 none, 1 Sb, 2 Sh, 3 Sw
- addr  input  32  byte address
- wdata  input  32  store data (low bytes used for Sb/Sh)
- hc_data  input  32  hardware counter value
- rsp_valid  output  1  one-cycle completion pulse
- rsp_data  output  32  extended load data; 0 for stores
- misalign_err  output  1  pulses with rsp_valid (feature off only)
- mem_req_valid  output  1  memory request
- mem_req_ready  input  1  memory accepts request
- mem_we  output  1  1 write, 0 read
- mem_addr  output  MEM_AW  word address
- mem_be  output  4  byte enables, bit n = bits [8n+7:8n]
- mem_wdata  output  32  write data, byte-lane aligned
- mem_rsp_valid  input  1  one response per request, in order
- mem_rdata  input  32  read data, valid with mem_rsp_valid

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values: all outputs 0, except req_ready=1. State IDLE. Reset in any state aborts the access with no rsp_valid.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch all inputs.
  - info_store!=0 → store; info_store takes priority when both are nonzero.
  - Both zero → go to RESP, rsp_data=0.
  - Lw && addr==HC_ADDR → go to RESP, rsp_data=hc_data sampled at accept.
  - Otherwise go to REQ0.
- REQ0/REQ1:
  - mem_req_valid=1; payload is registered and held stable until mem_req_ready.
  - On handshake, go to WAIT0/WAIT1.
- WAIT0:
  - On mem_rsp_valid, capture mem_rdata into lo; go to REQ1 if split, else RESP.
- WAIT1:
  - On mem_rsp_valid, capture into hi; go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; return to IDLE the next cycle.
  - req_ready=0 in every state except IDLE.
- Latency, aligned access with zero-wait memory: accept at cycle 0, mem_req_valid at 1, mem_rsp_valid at 2, rsp_valid at 3.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored.
- Lane mapping: r=addr[1:0], size s = 1/2/4 bytes.
  - Split when r+s>4.
  - Beat 0: mem_addr=addr[31:2], be = ((1<<s)-1)<<r, truncated to 4 bits; wdata shifted left by 8r.
  - Beat 1: mem_addr=addr[31:2]+1, wrapping mod 2^MEM_AW; be = (1<<(r+s-4))-1; wdata shifted right by 8(4-r).
  - Reads: mem_we=0. Beat be values are still driven (informational).
- Load merge:
  - {hi,lo} is a 64-bit value; extract s bytes starting at byte r.
  - Lb/Lh sign-extend; Lbu/Lhu/Lw zero-extend or pass through.
- rsp_data is 0 for stores. rsp_data is held until the next rsp_valid.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split as above; misalign_err is tied to 0.
- Undefined:
  - Any access with r+s>4 issues no memory transaction and goes IDLE→RESP.
  - rsp_valid and misalign_err pulse together; rsp_data=0; no memory write occurs.
  - Beat-1 states are not implemented.

Test Plan:
- Lw addr 0x100, mem_rdata 0xDEADBEEF, ready/rsp zero-wait → mem_addr 0x40, be 4'hF, mem_we 0; rsp_valid at cycle 3, rsp_data 0xDEADBEEF.
- Lb addr 0x103, rdata 0x80FF_FF12 → be 4'b1000, rsp_data 0xFFFFFF80. Same with Lbu → 0x00000080.
- Sw addr 0x102, wdata 0xAABBCCDD (feature on):
  - beat 0: word 0x40, be 4'b1100, mem_wdata 0xCCDD0000
  - beat 1: word 0x41, be 4'b0011, mem_wdata 0x0000AABB
  - one rsp_valid, rsp_data 0.
- Lh addr 0x1FF, beat rdata 0x34000000 then 0x00000092 → words 0x7F then 0x80, rsp_data 0xFFFF9234.
- Lw addr 0x102 with feature off → no mem_req_valid; rsp_valid and misalign_err both pulse at cycle 1.
- Lw addr 0x40, mem_req_ready low for 5 cycles → mem_req_valid/mem_addr/mem_be stable and req_ready 0 throughout. Then assert rst in WAIT0 → all outputs 0 and req_ready 1 immediately; a later mem_rsp_valid produces no rsp_valid.

Source files
------------

// File: rtl/lsu_master.sv
// Load/store initiator: turns one pipeline load/store into word-wide memory beats
// with byte enables. Define LSU_MISALIGN_SPLIT_EN to split lane-crossing accesses into two beats.
module lsu_master #(
  parameter int unsigned MEM_AW  = 30,
  parameter logic [31:0] HC_ADDR = 32'hFFFF_FF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        info_load,
  input  logic [1:0]        info_store,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       hc_data,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              misalign_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ0  = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd5;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic [2:0] S_REQ1  = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
`endif

  logic [2:0]        r_state;
  logic              r_store;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [2:0]        r_size;
  logic [31:0]       r_rsp_data;
  logic              r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic              r_split;
  logic [3:0]        r_be_hi;
  logic [31:0]       r_wdata_hi;
  logic [31:0]       r_lo;
  logic [7:0]        w_be_wide;
  logic [63:0]       w_wdata_wide;
  logic [63:0]       w_src;
`else
  logic              r_mis;
`endif

  logic              w_is_store;
  logic              w_signed;
  logic              w_is_lw;
  logic              w_split;
  logic [2:0]        w_size;
  logic [3:0]        w_mask;
  logic [3:0]        w_be0;
  logic [31:0]       w_wdata0;
  logic [MEM_AW-1:0] w_word0;
  logic [31:0]       w_shifted;
  logic [31:0]       w_ext;

  // Store decode wins when both info fields are nonzero.
  always_comb begin
    w_is_store = (info_store != 2'd0);
    w_size     = 3'd0;
    w_signed   = 1'b0;
    w_is_lw    = 1'b0;
    if (w_is_store) begin
      case (info_store)
        2'd1:    w_size = 3'd1;
        2'd2:    w_size = 3'd2;
        default: w_size = 3'd4;
      endcase
    end else begin
      case (info_load)
        3'd1:    begin w_size = 3'd1; w_signed = 1'b1; end
        3'd2:    begin w_size = 3'd2; w_signed = 1'b1; end
        3'd3:    begin w_size = 3'd4; w_is_lw  = 1'b1; end
        3'd4:    w_size = 3'd1;
        3'd5:    w_size = 3'd2;
        default: w_size = 3'd0;
      endcase
    end
  end

  always_comb begin
    case (w_size)
      3'd1:    w_mask = 4'b0001;
      3'd2:    w_mask = 4'b0011;
      3'd4:    w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  assign w_split = ({1'b0, addr[1:0]} + w_size) > 3'd4;
  assign w_word0 = addr[MEM_AW+1:2];

`ifdef LSU_MISALIGN_SPLIT_EN
  // Upper halves of the widened lane shift are exactly the second beat's be/wdata.
  assign w_be_wide    = {4'b0000, w_mask} << addr[1:0];
  assign w_wdata_wide = {32'h0, wdata} << {addr[1:0], 3'b000};
  assign w_be0        = w_be_wide[3:0];
  assign w_wdata0     = w_wdata_wide[31:0];
  assign w_src        = (r_state == S_WAIT1) ? {mem_rdata, r_lo} : {32'h0, mem_rdata};
  assign w_shifted    = 32'(w_src >> {r_off, 3'b000});
`else
  assign w_be0        = w_mask << addr[1:0];
  assign w_wdata0     = wdata << {addr[1:0], 3'b000};
  assign w_shifted    = mem_rdata >> {r_off, 3'b000};
`endif

  always_comb begin
    case (r_size)
      3'd1:    w_ext = r_signed ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                : {24'h0, w_shifted[7:0]};
      3'd2:    w_ext = r_signed ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                : {16'h0, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_store     <= 1'b0;
      r_signed    <= 1'b0;
      r_off       <= '0;
      r_size      <= '0;
      r_rsp_data  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split     <= 1'b0;
      r_be_hi     <= '0;
      r_wdata_hi  <= '0;
      r_lo        <= '0;
`else
      r_mis       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store  <= w_is_store;
            r_signed <= w_signed;
            r_size   <= w_size;
            r_off    <= addr[1:0];
`ifndef LSU_MISALIGN_SPLIT_EN
            r_mis    <= 1'b0;
`endif
            if (w_size == 3'd0) begin
              r_rsp_data <= '0;
              r_state    <= S_RESP;
            end else if (w_is_lw && (addr == HC_ADDR)) begin
              r_rsp_data <= hc_data;
              r_state    <= S_RESP;
`ifndef LSU_MISALIGN_SPLIT_EN
            end else if (w_split) begin
              r_rsp_data <= '0;
              r_mis      <= 1'b1;
              r_state    <= S_RESP;
`endif
            end else begin
              r_mem_we    <= w_is_store;
              r_mem_addr  <= w_word0;
              r_mem_be    <= w_be0;
              r_mem_wdata <= w_wdata0;
`ifdef LSU_MISALIGN_SPLIT_EN
              r_split     <= w_split;
              r_be_hi     <= w_be_wide[7:4];
              r_wdata_hi  <= w_wdata_wide[63:32];
`endif
              r_state     <= S_REQ0;
            end
          end
        end
        S_REQ0: if (mem_req_ready) r_state <= S_WAIT0;
        S_WAIT0: begin
          if (mem_rsp_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            r_lo <= mem_rdata;
            if (r_split) begin
              r_mem_addr  <= r_mem_addr + MEM_AW'(1);
              r_mem_be    <= r_be_hi;
              r_mem_wdata <= r_wdata_hi;
              r_state     <= S_REQ1;
            end else begin
              r_rsp_data <= r_store ? '0 : w_ext;
              r_state    <= S_RESP;
            end
`else
            r_rsp_data <= r_store ? '0 : w_ext;
            r_state    <= S_RESP;
`endif
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        S_REQ1: if (mem_req_ready) r_state <= S_WAIT1;
        S_WAIT1: begin
          if (mem_rsp_valid) begin
            r_rsp_data <= r_store ? '0 : w_ext;
            r_state    <= S_RESP;
          end
        end
`endif
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rsp_data;
`ifdef LSU_MISALIGN_SPLIT_EN
  assign mem_req_valid = (r_state == S_REQ0) || (r_state == S_REQ1);
  assign misalign_err  = 1'b0;
`else
  assign mem_req_valid = (r_state == S_REQ0);
  assign misalign_err  = rsp_valid & r_mis;
`endif
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_master.sv
// Bench for lsu_master: directed vector table, multi-cycle corner sequences,
// and randomized accesses against a byte-level reference model.
module tb_lsu_master;
  localparam int unsigned AW = 30;
  localparam logic [31:0] HC = 32'hFFFF_FF00;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    info_load = '0;
  logic [1:0]    info_store = '0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   hc_data = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          misalign_err;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_rsp_valid = 1'b0;
  logic [31:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  lsu_master #(.MEM_AW(AW), .HC_ADDR(HC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .info_load(info_load), .info_store(info_store), .addr(addr), .wdata(wdata),
    .hc_data(hc_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .misalign_err(misalign_err), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] word;
    logic [3:0]    be;
    logic [31:0]   wd;
  } beat_t;

  typedef struct {
    logic [2:0]    ld;
    logic [1:0]    st;
    logic [31:0]   a;
    logic [31:0]   wd;
    logic [31:0]   rd;
    logic [31:0]   exp_rsp;
    int            nb;
    logic [AW-1:0] w0;
    logic [3:0]    be0;
    logic          we;
    logic [31:0]   exp_wd;
    int            cyc;
  } vec_t;

  beat_t         log_q[$];
  logic [31:0]   pend[$];
  logic [31:0]   mem [logic [AW-1:0]];
  bit            rdy_rand = 0, rsp_rand = 0, rdy_force0 = 0, rsp_hold = 0, inject = 0, saw_mreq = 0;
  int            total = 0, bad = 0;
  beat_t         rb;
  bit            rhs;
  logic [31:0]   rtmp;

  function automatic logic [31:0] rd_word(input logic [AW-1:0] w);
    if (mem.exists(w)) return mem[w];
    return {w[29:0], 2'b01} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] bemask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Memory responder: in-order responses, optional random stalls.
  always @(posedge clk) begin
    rhs     = mem_req_valid && mem_req_ready;
    rb.we   = mem_we;
    rb.word = mem_addr;
    rb.be   = mem_be;
    rb.wd   = mem_wdata;
    if (mem_req_valid) saw_mreq = 1;
    #1;
    mem_rsp_valid = 1'b0;
    mem_rdata     = $urandom;
    if (rhs) begin
      log_q.push_back(rb);
      if (rb.we) begin
        rtmp = rd_word(rb.word);
        for (int i = 0; i < 4; i++) if (rb.be[i]) rtmp[8*i +: 8] = rb.wd[8*i +: 8];
        mem[rb.word] = rtmp;
      end
      pend.push_back(rb.we ? $urandom : rd_word(rb.word));
    end
    if (inject) begin
      mem_rsp_valid = 1'b1;
      inject = 0;
    end else if (!rsp_hold && pend.size() > 0 && (!rsp_rand || $urandom_range(0, 2) != 0)) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = pend.pop_front();
    end
    mem_req_ready = rdy_force0 ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                       input logic [31:0] wd, output bit got, output logic [31:0] data,
                       output logic mis, output int cyc);
    log_q.delete();
    saw_mreq = 0;
    @(negedge clk);
    req_valid = 1'b1; info_load = ld; info_store = st; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    info_load = 3'($urandom); info_store = 2'($urandom);
    addr = $urandom; wdata = $urandom; hc_data = $urandom;
    got = 0; data = '0; mis = 1'b0; cyc = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1; data = rsp_data; mis = misalign_err; cyc = n;
        break;
      end
    end
  endtask

  vec_t          tv[12];
  vec_t          v;
  bit            got;
  logic [31:0]   data;
  logic          mis;
  int            cyc;
  bit            seen;

  initial begin
    tv[0]  = '{3'd3, 2'd0, 32'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1, 30'h40, 4'hF, 1'b0, 32'h0,        3};
    tv[1]  = '{3'd1, 2'd0, 32'h103, 32'h0,        32'h80FFFF12, 32'hFFFFFF80, 1, 30'h40, 4'h8, 1'b0, 32'h0,        3};
    tv[2]  = '{3'd4, 2'd0, 32'h103, 32'h0,        32'h80FFFF12, 32'h00000080, 1, 30'h40, 4'h8, 1'b0, 32'h0,        3};
    tv[3]  = '{3'd2, 2'd0, 32'h102, 32'h0,        32'h80011234, 32'hFFFF8001, 1, 30'h40, 4'hC, 1'b0, 32'h0,        3};
    tv[4]  = '{3'd5, 2'd0, 32'h100, 32'h0,        32'h1234F00D, 32'h0000F00D, 1, 30'h40, 4'h3, 1'b0, 32'h0,        3};
    tv[5]  = '{3'd0, 2'd1, 32'h101, 32'h12345678, 32'h0,        32'h0,        1, 30'h40, 4'h2, 1'b1, 32'h00007800, 3};
    tv[6]  = '{3'd0, 2'd2, 32'h102, 32'hCAFEBEEF, 32'h0,        32'h0,        1, 30'h40, 4'hC, 1'b1, 32'hBEEF0000, 3};
    tv[7]  = '{3'd3, 2'd1, 32'h200, 32'h00000055, 32'h0,        32'h0,        1, 30'h80, 4'h1, 1'b1, 32'h00000055, 3};
    tv[8]  = '{3'd0, 2'd0, 32'h300, 32'h0,        32'h1,        32'h0,        0, 30'h0,  4'h0, 1'b0, 32'h0,        1};
    tv[9]  = '{3'd3, 2'd0, HC,      32'h0,        32'h13572468, 32'h13572468, 0, 30'h0,  4'h0, 1'b0, 32'h0,        1};
    tv[10] = '{3'd1, 2'd0, HC,      32'h0,        32'h0000007F, 32'h0000007F, 1, 30'h3FFFFFC0, 4'h1, 1'b0, 32'h0, 3};
    tv[11] = '{3'd2, 2'd0, 32'h106, 32'h0,        32'h7FFF0000, 32'h00007FFF, 1, 30'h41, 4'hC, 1'b0, 32'h0,        3};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      v = tv[i];
      mem[v.w0] = v.rd;
      hc_data   = v.rd;
      do_op(v.ld, v.st, v.a, v.wd, got, data, mis, cyc);
      chk($sformatf("v%0d_rsp_seen", i), 32'(got), 32'h1);
      chk($sformatf("v%0d_rsp_data", i), data, v.exp_rsp);
      chk($sformatf("v%0d_misalign", i), 32'(mis), 32'h0);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(v.cyc));
      chk($sformatf("v%0d_nbeats", i), 32'(log_q.size()), 32'(v.nb));
      if (v.nb > 0 && log_q.size() > 0) begin
        chk($sformatf("v%0d_word", i), 32'(log_q[0].word), 32'(v.w0));
        chk($sformatf("v%0d_be", i), 32'(log_q[0].be), 32'(v.be0));
        chk($sformatf("v%0d_we", i), 32'(log_q[0].we), 32'(v.we));
        if (v.we) chk($sformatf("v%0d_wdata", i), log_q[0].wd & bemask(log_q[0].be), v.exp_wd);
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("rsp_data_held", rsp_data, 32'h00007FFF);

`ifdef LSU_MISALIGN_SPLIT_EN
    do_op(3'd0, 2'd3, 32'h102, 32'hAABBCCDD, got, data, mis, cyc);
    chk("sw_split_seen", 32'(got), 32'h1);
    chk("sw_split_rsp", data, 32'h0);
    chk("sw_split_nbeats", 32'(log_q.size()), 32'h2);
    if (log_q.size() == 2) begin
      chk("sw_b0_word", 32'(log_q[0].word), 32'h40);
      chk("sw_b0_be", 32'(log_q[0].be), 32'hC);
      chk("sw_b0_wdata", log_q[0].wd, 32'hCCDD0000);
      chk("sw_b1_word", 32'(log_q[1].word), 32'h41);
      chk("sw_b1_be", 32'(log_q[1].be), 32'h3);
      chk("sw_b1_wdata", log_q[1].wd, 32'h0000AABB);
    end
    mem[30'h7F] = 32'h34000000;
    mem[30'h80] = 32'h00000092;
    do_op(3'd2, 2'd0, 32'h1FF, 32'h0, got, data, mis, cyc);
    chk("lh_split_rsp", data, 32'hFFFF9234);
    chk("lh_split_nbeats", 32'(log_q.size()), 32'h2);
    if (log_q.size() == 2) begin
      chk("lh_b0_word", 32'(log_q[0].word), 32'h7F);
      chk("lh_b1_word", 32'(log_q[1].word), 32'h80);
      chk("lh_b0_be", 32'(log_q[0].be), 32'h8);
      chk("lh_b1_be", 32'(log_q[1].be), 32'h1);
    end
`else
    do_op(3'd3, 2'd0, 32'h102, 32'h0, got, data, mis, cyc);
    chk("mis_lw_seen", 32'(got), 32'h1);
    chk("mis_lw_latency", 32'(cyc), 32'h1);
    chk("mis_lw_err", 32'(mis), 32'h1);
    chk("mis_lw_rsp", data, 32'h0);
    chk("mis_lw_no_mreq", 32'(saw_mreq), 32'h0);
    do_op(3'd0, 2'd3, 32'h102, 32'hAABBCCDD, got, data, mis, cyc);
    chk("mis_sw_err", 32'(mis), 32'h1);
    chk("mis_sw_no_write", 32'(log_q.size()), 32'h0);
`endif

    // Stalled request channel, then reset while waiting for the response.
    rdy_force0 = 1;
    @(posedge clk);
    #2;
    log_q.delete();
    do_stall();

    rdy_rand = 1;
    rsp_rand = 1;
    for (int t = 0; t < 250; t++) rand_op(t);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic do_stall();
    @(negedge clk);
    req_valid = 1'b1; info_load = 3'd3; info_store = 2'd0; addr = 32'h40; wdata = 32'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_mreq_valid", k), 32'(mem_req_valid), 32'h1);
      chk($sformatf("stall%0d_mem_addr", k), 32'(mem_addr), 32'h10);
      chk($sformatf("stall%0d_mem_be", k), 32'(mem_be), 32'hF);
      chk($sformatf("stall%0d_req_ready", k), 32'(req_ready), 32'h0);
    end
    rsp_hold   = 1;
    rdy_force0 = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("stall_handshake_done", 32'(log_q.size()), 32'h1);
    chk("wait0_no_mreq", 32'(mem_req_valid), 32'h0);
    rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'h1);
    chk("arst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    chk("arst_mem_addr", 32'(mem_addr), 32'h0);
    chk("arst_mem_be", 32'(mem_be), 32'h0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("arst_misalign", 32'(misalign_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    rsp_hold = 0;
    inject   = 1;
    seen     = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("stray_rsp_ignored", 32'(seen), 32'h0);
  endtask

  task automatic rand_op(input int t);
    logic [2:0]    ld;
    logic [1:0]    st;
    logic [31:0]   a, wd, ba, val, exp_rsp;
    logic [AW-1:0] ew[2];
    logic [3:0]    ebe[2];
    logic [31:0]   ewd[2];
    int            nb, s, kind;
    bit            sgn, exp_mis, splitting;
    logic [7:0]    bt;

    kind = $urandom_range(0, 9);
    a  = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0000_0100) + 32'($urandom_range(0, 31));
    wd = $urandom;
    ld = 3'd0;
    st = 2'd0;
    if (kind <= 4) ld = 3'($urandom_range(1, 5));
    else if (kind <= 8) begin
      st = 2'($urandom_range(1, 3));
      ld = 3'($urandom_range(0, 5));
    end else if ($urandom_range(0, 1) == 1) begin
      ld = 3'd3;
      a  = HC;
    end
    hc_data = $urandom;

    s = 0; sgn = 0;
    if (st != 0) s = (st == 1) ? 1 : (st == 2) ? 2 : 4;
    else if (ld != 0) begin
      s   = (ld == 1 || ld == 4) ? 1 : (ld == 2 || ld == 5) ? 2 : 4;
      sgn = (ld == 1 || ld == 2);
    end

    nb = 0; exp_rsp = 0; exp_mis = 0; val = 0;
    splitting = (32'(a[1:0]) + 32'(s)) > 4;
`ifdef LSU_MISALIGN_SPLIT_EN
    splitting = 0;
`endif
    if (s == 0) begin
      exp_rsp = 0;
    end else if (st == 0 && ld == 3 && a == HC) begin
      exp_rsp = hc_data;
    end else if (splitting) begin
      exp_mis = 1;
    end else begin
      for (int i = 0; i < s; i++) begin
        ba = a + 32'(i);
        if (nb == 0 || ew[nb-1] != ba[31:2]) begin
          ew[nb] = ba[31:2]; ebe[nb] = 4'h0; ewd[nb] = 32'h0;
          nb++;
        end
        ebe[nb-1][ba[1:0]] = 1'b1;
        if (st != 0) ewd[nb-1][8*ba[1:0] +: 8] = wd[8*i +: 8];
        else begin
          bt = 8'(rd_word(ba[31:2]) >> (8 * ba[1:0]));
          val[8*i +: 8] = bt;
        end
      end
      if (st == 0) begin
        if (sgn && s == 1) exp_rsp = {{24{val[7]}}, val[7:0]};
        else if (sgn && s == 2) exp_rsp = {{16{val[15]}}, val[15:0]};
        else exp_rsp = val;
      end
    end

    do_op(ld, st, a, wd, got, data, mis, cyc);
    chk($sformatf("r%0d_seen", t), 32'(got), 32'h1);
    chk($sformatf("r%0d_rsp a=%h ld=%0d st=%0d", t, a, ld, st), data, exp_rsp);
    chk($sformatf("r%0d_misalign", t), 32'(mis), 32'(exp_mis));
    chk($sformatf("r%0d_nbeats", t), 32'(log_q.size()), 32'(nb));
    for (int j = 0; j < nb && j < log_q.size(); j++) begin
      chk($sformatf("r%0d_b%0d_word", t, j), 32'(log_q[j].word), 32'(ew[j]));
      chk($sformatf("r%0d_b%0d_be", t, j), 32'(log_q[j].be), 32'(ebe[j]));
      chk($sformatf("r%0d_b%0d_we", t, j), 32'(log_q[j].we), 32'(st != 0));
      if (st != 0)
        chk($sformatf("r%0d_b%0d_wdata", t, j), log_q[j].wd & bemask(ebe[j]), ewd[j]);
    end
  endtask

endmodule
